// File: rtl/axis_meta_rr_arb.sv
// axis_meta_rr_arb
// Packet-aware round-robin arbiter. It merges NUM_IN rx_meta requester
// streams onto one tx_meta stream through a single output register stage.
// A requester holds the grant from its first beat until the beat that
// carries eop, so beats from different packets are never interleaved.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   rx_meta_*         per-port requester beats (port i at [i*W +: W])
//   rx_meta_rdy       per-port ready, at most one bit high per cycle
//   tx_meta_*         registered winner beat, vld/sop/eop, source index
//   tx_meta_rdy       downstream ready
//   drop_cnt          stray-beat counter, saturating (macro builds only)
//
// Build option: define AXIS_ARB_SOP_CHK_EN to make only sop heads eligible
// in IDLE. A head without sop is then discarded and counted in drop_cnt.
module axis_meta_rr_arb #(
  parameter  int NUM_IN = 4,
  parameter  int DATA_W = 128,
  parameter  int KEEP_W = 16,
  parameter  int TID_W  = 4,
  parameter  int TDT_W  = 4,
  localparam int SRC_W  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_IN*DATA_W-1:0] rx_meta_data,
  input  logic [NUM_IN*KEEP_W-1:0] rx_meta_keep,
  input  logic [NUM_IN-1:0]        rx_meta_vld,
  input  logic [NUM_IN*TID_W-1:0]  rx_meta_tid,
  input  logic [NUM_IN*TDT_W-1:0]  rx_meta_tdt,
  input  logic [NUM_IN-1:0]        rx_meta_sop,
  input  logic [NUM_IN-1:0]        rx_meta_eop,
  output logic [NUM_IN-1:0]        rx_meta_rdy,
  output logic [DATA_W-1:0]        tx_meta_data,
  output logic [KEEP_W-1:0]        tx_meta_keep,
  output logic [TID_W-1:0]         tx_meta_tid,
  output logic [TDT_W-1:0]         tx_meta_tdt,
  output logic                     tx_meta_vld,
  output logic                     tx_meta_sop,
  output logic                     tx_meta_eop,
  output logic [SRC_W-1:0]         tx_meta_src,
  input  logic                     tx_meta_rdy
`ifdef AXIS_ARB_SOP_CHK_EN
  ,
  output logic [15:0]              drop_cnt
`endif
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_LOCK = 1'b1;

  // First set bit of req at or after ptr, wrapping; returns {found, index}.
  function automatic logic [SRC_W:0] rr_pick(input logic [NUM_IN-1:0] req,
                                              input logic [SRC_W-1:0]  ptr);
    logic             found;
    logic [SRC_W-1:0] sel;
    int               idx;
    found = 1'b0;
    sel   = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      idx = (int'(ptr) + k) % NUM_IN;
      if (!found && req[idx]) begin
        found = 1'b1;
        sel   = SRC_W'(idx);
      end
    end
    return {found, sel};
  endfunction

  // Port index plus one, modulo NUM_IN.
  function automatic logic [SRC_W-1:0] ptr_inc(input logic [SRC_W-1:0] p);
    if (p == SRC_W'(NUM_IN - 1)) return '0;
    else                         return p + SRC_W'(1);
  endfunction

  logic [0:0]        r_state;
  logic [SRC_W-1:0]  r_grant;
  logic [SRC_W-1:0]  r_rr_ptr;
  logic [DATA_W-1:0] r_tx_data;
  logic [KEEP_W-1:0] r_tx_keep;
  logic [TID_W-1:0]  r_tx_tid;
  logic [TDT_W-1:0]  r_tx_tdt;
  logic              r_tx_vld;
  logic              r_tx_sop;
  logic              r_tx_eop;
  logic [SRC_W-1:0]  r_tx_src;

  logic              w_load_en;
  logic [NUM_IN-1:0] w_elig;
  logic [SRC_W:0]    w_win_pick;
  logic              w_win_found;
  logic [SRC_W-1:0]  w_win;
  logic [NUM_IN-1:0] w_rdy;
  logic [SRC_W-1:0]  w_sel;
  logic              w_drop;
  logic              w_acc;
  logic              w_fwd;
  logic              w_sel_eop;

  assign w_load_en = !r_tx_vld || tx_meta_rdy;

`ifdef AXIS_ARB_SOP_CHK_EN
  logic [15:0]       r_drop_cnt;
  logic [SRC_W:0]    w_stray_pick;
  logic              w_stray_found;
  logic [SRC_W-1:0]  w_stray;

  assign w_elig       = rx_meta_vld & rx_meta_sop;
  assign w_stray_pick = rr_pick(rx_meta_vld & ~rx_meta_sop, r_rr_ptr);
  assign {w_stray_found, w_stray} = w_stray_pick;
  assign drop_cnt     = r_drop_cnt;
`else
  assign w_elig = rx_meta_vld;
`endif

  assign w_win_pick = rr_pick(w_elig, r_rr_ptr);
  assign {w_win_found, w_win} = w_win_pick;

  // Ready generation and beat-source selection. Only the port chosen for
  // this cycle sees ready; a stray head is sunk only when no packet wins.
  always_comb begin
    w_rdy  = '0;
    w_sel  = r_grant;
    w_drop = 1'b0;
    if (rst) begin
      w_rdy = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_win_found) begin
            w_sel        = w_win;
            w_rdy[w_win] = w_load_en;
`ifdef AXIS_ARB_SOP_CHK_EN
          end else if (w_stray_found) begin
            // Discarded beats never reach tx, so they do not wait for load_en.
            w_sel          = w_stray;
            w_rdy[w_stray] = 1'b1;
            w_drop         = 1'b1;
`endif
          end else begin
            w_sel = r_rr_ptr;
          end
        end
        ST_LOCK: begin
          w_rdy[r_grant] = w_load_en;
        end
        default: begin
          w_rdy = '0;
        end
      endcase
    end
  end

  assign rx_meta_rdy = w_rdy;
  assign w_acc       = |(w_rdy & rx_meta_vld);
  assign w_fwd       = w_acc && !w_drop;
  assign w_sel_eop   = rx_meta_eop[w_sel];

  // Output register stage: loads the accepted beat, holds while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_data <= '0;
      r_tx_keep <= '0;
      r_tx_tid  <= '0;
      r_tx_tdt  <= '0;
      r_tx_vld  <= 1'b0;
      r_tx_sop  <= 1'b0;
      r_tx_eop  <= 1'b0;
      r_tx_src  <= '0;
    end else if (w_load_en) begin
      r_tx_vld <= w_fwd;
      if (w_fwd) begin
        r_tx_data <= rx_meta_data[int'(w_sel)*DATA_W +: DATA_W];
        r_tx_keep <= rx_meta_keep[int'(w_sel)*KEEP_W +: KEEP_W];
        r_tx_tid  <= rx_meta_tid[int'(w_sel)*TID_W +: TID_W];
        r_tx_tdt  <= rx_meta_tdt[int'(w_sel)*TDT_W +: TDT_W];
        r_tx_sop  <= rx_meta_sop[w_sel];
        r_tx_eop  <= w_sel_eop;
        r_tx_src  <= w_sel;
      end
    end
  end

  // Arbitration state: grant is held from first beat until eop is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_grant  <= '0;
      r_rr_ptr <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_fwd) begin
            if (w_sel_eop) begin
              r_rr_ptr <= ptr_inc(w_sel);
            end else begin
              r_grant <= w_sel;
              r_state <= ST_LOCK;
            end
          end
        end
        ST_LOCK: begin
          if (w_fwd && w_sel_eop) begin
            r_state  <= ST_IDLE;
            r_rr_ptr <= ptr_inc(r_grant);
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef AXIS_ARB_SOP_CHK_EN
  // Stray-beat counter, saturating.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_drop_cnt <= 16'h0000;
    end else if (w_drop && w_acc && (r_drop_cnt != 16'hFFFF)) begin
      r_drop_cnt <= r_drop_cnt + 16'h0001;
    end
  end
`endif

  assign tx_meta_data = r_tx_data;
  assign tx_meta_keep = r_tx_keep;
  assign tx_meta_tid  = r_tx_tid;
  assign tx_meta_tdt  = r_tx_tdt;
  assign tx_meta_vld  = r_tx_vld;
  assign tx_meta_sop  = r_tx_sop;
  assign tx_meta_eop  = r_tx_eop;
  assign tx_meta_src  = r_tx_src;

endmodule

// File: tb/tb_axis_meta_rr_arb.sv
// Directed bench for axis_meta_rr_arb. Per-port source queues feed the
// requesters; every packet whose arrival order on tx is known is pushed to
// a scoreboard when it is queued and compared when tx hands it off.
module tb_axis_meta_rr_arb;
  localparam int NUM_IN = 4;
  localparam int DATA_W = 128;
  localparam int KEEP_W = 16;
  localparam int TID_W  = 4;
  localparam int TDT_W  = 4;
  localparam int SRC_W  = 2;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [KEEP_W-1:0] keep;
    logic [TID_W-1:0]  tid;
    logic [TDT_W-1:0]  tdt;
    logic              sop;
    logic              eop;
    logic [SRC_W-1:0]  src;
  } beat_t;

  logic                     clk;
  logic                     rst;
  logic                     rst_next;
  logic [NUM_IN*DATA_W-1:0] rx_meta_data;
  logic [NUM_IN*KEEP_W-1:0] rx_meta_keep;
  logic [NUM_IN-1:0]        rx_meta_vld;
  logic [NUM_IN*TID_W-1:0]  rx_meta_tid;
  logic [NUM_IN*TDT_W-1:0]  rx_meta_tdt;
  logic [NUM_IN-1:0]        rx_meta_sop;
  logic [NUM_IN-1:0]        rx_meta_eop;
  logic [NUM_IN-1:0]        rx_meta_rdy;
  logic [DATA_W-1:0]        tx_meta_data;
  logic [KEEP_W-1:0]        tx_meta_keep;
  logic [TID_W-1:0]         tx_meta_tid;
  logic [TDT_W-1:0]         tx_meta_tdt;
  logic                     tx_meta_vld;
  logic                     tx_meta_sop;
  logic                     tx_meta_eop;
  logic [SRC_W-1:0]         tx_meta_src;
  logic                     tx_meta_rdy;
`ifdef AXIS_ARB_SOP_CHK_EN
  logic [15:0]              drop_cnt;
`endif

  axis_meta_rr_arb dut (
    .clk          (clk),
    .rst          (rst),
    .rx_meta_data (rx_meta_data),
    .rx_meta_keep (rx_meta_keep),
    .rx_meta_vld  (rx_meta_vld),
    .rx_meta_tid  (rx_meta_tid),
    .rx_meta_tdt  (rx_meta_tdt),
    .rx_meta_sop  (rx_meta_sop),
    .rx_meta_eop  (rx_meta_eop),
    .rx_meta_rdy  (rx_meta_rdy),
    .tx_meta_data (tx_meta_data),
    .tx_meta_keep (tx_meta_keep),
    .tx_meta_tid  (tx_meta_tid),
    .tx_meta_tdt  (tx_meta_tdt),
    .tx_meta_vld  (tx_meta_vld),
    .tx_meta_sop  (tx_meta_sop),
    .tx_meta_eop  (tx_meta_eop),
    .tx_meta_src  (tx_meta_src),
    .tx_meta_rdy  (tx_meta_rdy)
`ifdef AXIS_ARB_SOP_CHK_EN
    ,
    .drop_cnt     (drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  beat_t src_q [NUM_IN][$];
  beat_t exp_q [$];
  int    n_checks  = 0;
  int    n_errors  = 0;
  int    cycle     = 0;
  int    beats_seen;
  int    first_cyc;
  int    last_cyc;
  logic  hold_vld  = 1'b0;
  logic [DATA_W-1:0] held_data;
  logic [SRC_W+1:0]  held_ctrl;

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic beat_t make_beat(input int port, input logic sop, input logic eop);
    beat_t b;
    b.data = {$urandom, $urandom, $urandom, $urandom};
    b.keep = KEEP_W'($urandom);
    b.tid  = TID_W'($urandom);
    b.tdt  = TDT_W'($urandom);
    b.sop  = sop;
    b.eop  = eop;
    b.src  = SRC_W'(port);
    return b;
  endfunction

  task automatic add_pkt(input int port, input int n);
    beat_t b;
    for (int k = 0; k < n; k++) begin
      b = make_beat(port, (k == 0), (k == n - 1));
      src_q[port].push_back(b);
      exp_q.push_back(b);
    end
  endtask

  function automatic bit pending();
    bit p;
    p = (exp_q.size() > 0);
    for (int i = 0; i < NUM_IN; i++) if (src_q[i].size() > 0) p = 1'b1;
    return p;
  endfunction

  function automatic void clear_stats();
    beats_seen = 0;
    first_cyc  = -1;
    last_cyc   = -1;
  endfunction

  // One clock: drive at negedge, sample 1 ns later, retire accepted beats.
  task automatic step(input logic trdy);
    beat_t b;
    beat_t e;
    logic [NUM_IN-1:0] acc;
    @(negedge clk);
    rst         = rst_next;
    tx_meta_rdy = trdy;
    for (int i = 0; i < NUM_IN; i++) begin
      if (src_q[i].size() > 0) begin
        b = src_q[i][0];
        rx_meta_vld[i] = 1'b1;
      end else begin
        b = '{default: '0};
        rx_meta_vld[i] = 1'b0;
      end
      rx_meta_data[i*DATA_W +: DATA_W] = b.data;
      rx_meta_keep[i*KEEP_W +: KEEP_W] = b.keep;
      rx_meta_tid[i*TID_W +: TID_W]    = b.tid;
      rx_meta_tdt[i*TDT_W +: TDT_W]    = b.tdt;
      rx_meta_sop[i]                   = b.sop;
      rx_meta_eop[i]                   = b.eop;
    end
    #1;
    if (hold_vld) begin
      chk("stall_data", tx_meta_data, held_data);
      chk("stall_ctrl", {tx_meta_vld, tx_meta_src, tx_meta_eop}, held_ctrl);
    end
    hold_vld  = tx_meta_vld && !tx_meta_rdy;
    held_data = tx_meta_data;
    held_ctrl = {tx_meta_vld, tx_meta_src, tx_meta_eop};
    if (tx_meta_vld && tx_meta_rdy) begin
      beats_seen++;
      if (first_cyc < 0) first_cyc = cycle;
      last_cyc = cycle;
      chk("sb_nonempty", DATA_W'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("tx_data", tx_meta_data, e.data);
        chk("tx_ctrl", {tx_meta_keep, tx_meta_tid, tx_meta_tdt, tx_meta_src, tx_meta_sop, tx_meta_eop},
                       {e.keep, e.tid, e.tdt, e.src, e.sop, e.eop});
      end
    end
    chk("rdy_onehot", DATA_W'($countones(rx_meta_rdy) <= 1), 1);
    acc = rx_meta_vld & rx_meta_rdy;
    for (int i = 0; i < NUM_IN; i++) if (acc[i]) void'(src_q[i].pop_front());
    cycle++;
  endtask

  task automatic drain(input bit toggle);
    int   n;
    logic t;
    n = 0;
    t = 1'b1;
    while (pending() && n < 400) begin
      step(toggle ? t : 1'b1);
      t = ~t;
      n++;
    end
    chk("drain_budget", DATA_W'(n < 400), 1);
    step(1'b1);
    chk("idle_rdy", rx_meta_rdy, 0);
  endtask

  initial begin
    int n;
    logic t;
    beat_t b;
    rst          = 1'b1;
    rst_next     = 1'b1;
    tx_meta_rdy  = 1'b0;
    rx_meta_data = '0;
    rx_meta_keep = '0;
    rx_meta_vld  = '0;
    rx_meta_tid  = '0;
    rx_meta_tdt  = '0;
    rx_meta_sop  = '0;
    rx_meta_eop  = '0;
    clear_stats();

    // T1: reset with every port requesting, then release
    for (int p = 0; p < NUM_IN; p++) add_pkt(p, 1);
    for (int k = 0; k < 3; k++) begin
      step(1'b1);
      chk("T1_rst_rdy", rx_meta_rdy, 0);
      chk("T1_rst_vld", tx_meta_vld, 0);
      chk("T1_rst_src", tx_meta_src, 0);
`ifdef AXIS_ARB_SOP_CHK_EN
      chk("T1_rst_drop", drop_cnt, 0);
`endif
    end
    rst_next = 1'b0;
    step(1'b1);
    chk("T1_first_rdy", rx_meta_rdy, 4'b0001);
    drain(1'b0);

    // T2: four 3-beat packets served 0,1,2,3 at full rate
    clear_stats();
    for (int p = 0; p < NUM_IN; p++) add_pkt(p, 3);
    drain(1'b0);
    chk("T2_beats", beats_seen, 12);
    chk("T2_span", last_cyc - first_cyc, 11);

    // T3: port1 locked with tx backpressure; ports 2 and 0 wait for eop
    add_pkt(1, 4);
    step(1'b1);
    add_pkt(2, 2);
    add_pkt(0, 2);
    n = 0;
    t = 1'b0;
    while (src_q[1].size() > 0 && n < 100) begin
      step(t);
      chk("T3_lockout", {rx_meta_rdy[0], rx_meta_rdy[2]}, 0);
      t = ~t;
      n++;
    end
    chk("T3_budget", DATA_W'(n < 100), 1);
    drain(1'b1);

    // T4: pointer at 3 after port2, ports 3 and 0 request -> 3 then 0
    add_pkt(2, 2);
    drain(1'b0);
    add_pkt(3, 2);
    add_pkt(0, 2);
    drain(1'b0);

    // T5: port2 single-beat packets back-to-back
    clear_stats();
    for (int k = 0; k < 5; k++) add_pkt(2, 1);
    n = 0;
    while (src_q[2].size() > 0 && n < 50) begin
      step(1'b1);
      chk("T5_rdy2", rx_meta_rdy[2], 1);
      n++;
    end
    drain(1'b0);
    chk("T5_beats", beats_seen, 5);
    chk("T5_span", last_cyc - first_cyc, 4);

`ifdef AXIS_ARB_SOP_CHK_EN
    // T6: stray head on port0 is discarded and counted; next packet passes
    b = make_beat(0, 1'b0, 1'b0);
    b.data = 128'h0000_0000_0000_0000_0000_0000_0000_00A5;
    src_q[0].push_back(b);
    add_pkt(0, 2);
    drain(1'b0);
    chk("T6_drop_cnt", drop_cnt, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
